// File: rtl/rf_pkg.sv
// Shared widths and FSM state encoding for the register-file write arbiter.
package rf_pkg;
  localparam int RF_ADDR_W = 4;
  localparam int RF_DATA_W = 16;
  localparam int RF_DEPTH  = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_INIT = 1'b1
  } rf_state_e;
endpackage

// File: rtl/rf_rr_pick.sv
// Two-way round-robin pick. A requester whose grant is still on the bus (busyN)
// sits out one edge so a held request is not granted twice in a row.
module rf_rr_pick (
  input  logic clk,
  input  logic nClear,
  input  logic en,
  input  logic req0,
  input  logic req1,
  input  logic busy0,
  input  logic busy1,
  output logic pick0,
  output logic pick1
);
  // last_q = 1 means requester 1 was granted last, so requester 0 wins a tie.
  logic last_q, last_d;
  logic elig0, elig1;

  always_comb begin
    elig0  = req0 & ~busy0;
    elig1  = req1 & ~busy1;
    pick0  = 1'b0;
    pick1  = 1'b0;
    last_d = last_q;
    if (en) begin
      if (elig0 && elig1) begin
        pick0 = last_q;
        pick1 = ~last_q;
      end else begin
        pick0 = elig0;
        pick1 = elig1;
      end
      if (pick0) begin
        last_d = 1'b0;
      end else if (pick1) begin
        last_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nClear) begin
    if (!nClear) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates two requesters onto one register-file write port, with an optional
// 16-entry init sweep compiled in by defining RF_ARB_INIT_EN.
module rf_write_arbiter
  import rf_pkg::*;
(
  input  logic                 clk,
  input  logic                 nClear,
  input  logic                 req0,
  input  logic                 req1,
  input  logic [RF_ADDR_W-1:0] addr0,
  input  logic [RF_ADDR_W-1:0] addr1,
  input  logic [RF_DATA_W-1:0] data0,
  input  logic [RF_DATA_W-1:0] data1,
  input  logic                 init_start,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 init_busy,
  output logic [RF_ADDR_W-1:0] Caddr,
  output logic [RF_DATA_W-1:0] C,
  output logic                 load,
  output logic                 dbg_state
);
  rf_state_e            state_q, state_d;
  logic                 gnt0_q, gnt0_d, gnt1_q, gnt1_d, load_q, load_d;
  logic [RF_ADDR_W-1:0] caddr_q, caddr_d;
  logic [RF_DATA_W-1:0] c_q, c_d;
  logic                 arb_en, pick0, pick1;

`ifdef RF_ARB_INIT_EN
  logic [RF_ADDR_W-1:0] idx_q, idx_d, idx_nxt;
  // init_start wins over any request sampled on the same edge.
  assign arb_en    = (state_q == ST_IDLE) && !init_start;
  assign init_busy = (state_q == ST_INIT);
`else
  logic unused_init_start;
  assign unused_init_start = init_start;
  assign arb_en    = (state_q == ST_IDLE);
  assign init_busy = 1'b0;
`endif

  rf_rr_pick u_pick (
    .clk   (clk),
    .nClear(nClear),
    .en    (arb_en),
    .req0  (req0),
    .req1  (req1),
    .busy0 (gnt0_q),
    .busy1 (gnt1_q),
    .pick0 (pick0),
    .pick1 (pick1)
  );

  always_comb begin
    state_d = state_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    load_d  = 1'b0;
    caddr_d = '0;
    c_d     = '0;
`ifdef RF_ARB_INIT_EN
    idx_d   = idx_q;
    idx_nxt = idx_q + 1'b1;
`endif
    case (state_q)
      ST_IDLE: begin
`ifdef RF_ARB_INIT_EN
        if (init_start) begin
          state_d = ST_INIT;
          idx_d   = '0;
          load_d  = 1'b1;
        end
`endif
        if (pick0) begin
          gnt0_d  = 1'b1;
          load_d  = 1'b1;
          caddr_d = addr0;
          c_d     = data0;
        end else if (pick1) begin
          gnt1_d  = 1'b1;
          load_d  = 1'b1;
          caddr_d = addr1;
          c_d     = data1;
        end
      end
`ifdef RF_ARB_INIT_EN
      // Entry 0 goes out on the entry edge; each INIT edge emits the next index.
      ST_INIT: begin
        if (idx_q == RF_ADDR_W'(RF_DEPTH - 1)) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else begin
          idx_d   = idx_nxt;
          load_d  = 1'b1;
          caddr_d = idx_nxt;
          c_d     = RF_DATA_W'(idx_nxt);
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nClear) begin
    if (!nClear) begin
      state_q <= ST_IDLE;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      load_q  <= 1'b0;
      caddr_q <= '0;
      c_q     <= '0;
`ifdef RF_ARB_INIT_EN
      idx_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      load_q  <= load_d;
      caddr_q <= caddr_d;
      c_q     <= c_d;
`ifdef RF_ARB_INIT_EN
      idx_q   <= idx_d;
`endif
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign load      = load_q;
  assign Caddr     = caddr_q;
  assign C         = c_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: vector table, write scoreboard and a
// register-file model, plus hand sequences for reset and the init sweep.
module tb_rf_write_arbiter;
  import rf_pkg::*;

  // Handshake: a write is accepted on the edge that registers gntN=1; the
  // register file captures Caddr/C whenever load=1 at the following edge.

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        nClear;
  logic        req0, req1, init_start;
  logic [3:0]  addr0, addr1;
  logic [15:0] data0, data1;
  logic        gnt0, gnt1, init_busy, load, dbg_state;
  logic [3:0]  Caddr;
  logic [15:0] C;

  always #5 clk = ~clk;

  rf_write_arbiter dut (
    .clk       (clk),
    .nClear    (nClear),
    .req0      (req0),
    .req1      (req1),
    .addr0     (addr0),
    .addr1     (addr1),
    .data0     (data0),
    .data1     (data1),
    .init_start(init_start),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .init_busy (init_busy),
    .Caddr     (Caddr),
    .C         (C),
    .load      (load),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int          n_pass  = 0;
  int          n_total = 0;
  logic [19:0] exp_q[$];
  logic [15:0] rf_mem[16];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_port(input string tag, input logic eg0, input logic eg1,
                            input logic el, input logic [3:0] ea,
                            input logic [15:0] ec, input logic eb);
    cmp({tag, ".gnt0"}, 32'(gnt0), 32'(eg0));
    cmp({tag, ".gnt1"}, 32'(gnt1), 32'(eg1));
    cmp({tag, ".load"}, 32'(load), 32'(el));
    cmp({tag, ".Caddr"}, 32'(Caddr), 32'(ea));
    cmp({tag, ".C"}, 32'(C), 32'(ec));
    cmp({tag, ".init_busy"}, 32'(init_busy), 32'(eb));
  endtask

  task automatic sb_observe();
    logic [19:0] e;
    if (load === 1'b1) begin
      rf_mem[Caddr] = C;
      if (exp_q.size() == 0) begin
        cmp("sb_write_expected", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        cmp("sb_write", 32'({Caddr, C}), 32'(e));
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    sb_observe();
  endtask

  // ---------------- driver ----------------
  typedef struct {
    logic        req0, req1;
    logic [3:0]  addr0, addr1;
    logic [15:0] data0, data1;
    logic        gnt0, gnt1, load;
    logic [3:0]  caddr;
    logic [15:0] c;
  } vec_t;

  vec_t vecs[13];

  task automatic drive(input logic r0, input logic r1, input logic [3:0] a0,
                       input logic [3:0] a1, input logic [15:0] d0, input logic [15:0] d1);
    req0 = r0; req1 = r1; addr0 = a0; addr1 = a1; data0 = d0; data1 = d1;
  endtask

  initial begin
    //        req0  req1  a0 a1  d0        d1         g0    g1    load  Caddr C
    vecs[0]  = '{1'b1, 1'b0, 3, 0, 16'h00AA, 16'h0000, 1'b1, 1'b0, 1'b1, 3, 16'h00AA};
    vecs[1]  = '{1'b1, 1'b0, 3, 0, 16'h00AA, 16'h0000, 1'b0, 1'b0, 1'b0, 0, 16'h0000};
    vecs[2]  = '{1'b1, 1'b0, 3, 0, 16'h00AA, 16'h0000, 1'b1, 1'b0, 1'b1, 3, 16'h00AA};
    vecs[3]  = '{1'b0, 1'b1, 0, 9, 16'h0000, 16'h1234, 1'b0, 1'b1, 1'b1, 9, 16'h1234};
    vecs[4]  = '{1'b0, 1'b0, 0, 0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 0, 16'h0000};
    vecs[5]  = '{1'b1, 1'b1, 4, 5, 16'd11,   16'd15,   1'b1, 1'b0, 1'b1, 4, 16'd11};
    vecs[6]  = '{1'b1, 1'b1, 4, 5, 16'd11,   16'd15,   1'b0, 1'b1, 1'b1, 5, 16'd15};
    vecs[7]  = '{1'b1, 1'b1, 4, 5, 16'd11,   16'd15,   1'b1, 1'b0, 1'b1, 4, 16'd11};
    vecs[8]  = '{1'b1, 1'b1, 4, 5, 16'd11,   16'd15,   1'b0, 1'b1, 1'b1, 5, 16'd15};
    vecs[9]  = '{1'b0, 1'b0, 0, 0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 0, 16'h0000};
    vecs[10] = '{1'b1, 1'b1, 7, 7, 16'h0001, 16'h0002, 1'b1, 1'b0, 1'b1, 7, 16'h0001};
    vecs[11] = '{1'b1, 1'b1, 7, 7, 16'h0001, 16'h0002, 1'b0, 1'b1, 1'b1, 7, 16'h0002};
    vecs[12] = '{1'b0, 1'b0, 0, 0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 0, 16'h0000};

    nClear = 1'b0;
    init_start = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #2;
    check_port("reset", 0, 0, 0, 0, 0, 0);
    cmp("reset.dbg_state", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge clk);
    #1;
    nClear = 1'b1;

    // First vector lands on the first edge after release.
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].req0, vecs[i].req1, vecs[i].addr0, vecs[i].addr1,
            vecs[i].data0, vecs[i].data1);
      if (vecs[i].load) exp_q.push_back({vecs[i].caddr, vecs[i].c});
      step();
      check_port($sformatf("vec%0d", i), vecs[i].gnt0, vecs[i].gnt1, vecs[i].load,
                 vecs[i].caddr, vecs[i].c, 1'b0);
    end

    cmp("rf_readback_A_addr4", 32'(rf_mem[4]), 32'd11);
    cmp("rf_readback_B_addr5", 32'(rf_mem[5]), 32'd15);

    // Asynchronous reset while a grant is on the bus.
    drive(1, 0, 6, 0, 16'h5A5A, 0);
    exp_q.push_back({4'd6, 16'h5A5A});
    step();
    check_port("pre_reset", 1, 0, 1, 6, 16'h5A5A, 0);
    #2;
    nClear = 1'b0;
    #1;
    check_port("async_reset", 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    step();
    nClear = 1'b1;

`ifdef RF_ARB_INIT_EN
    // Sweep with requester 1 pending; init_start wins the shared edge.
    drive(0, 1, 0, 2, 0, 16'hBEEF);
    init_start = 1'b1;
    exp_q.push_back(20'h0);
    step();
    init_start = 1'b0;
    check_port("init0", 0, 0, 1, 0, 0, 1);
    cmp("init0.dbg_state", 32'(dbg_state), 32'(ST_INIT));
    for (int i = 1; i < 16; i++) begin
      if (i == 5) init_start = 1'b1;
      exp_q.push_back({4'(i), 16'(i)});
      step();
      init_start = 1'b0;
      check_port($sformatf("init%0d", i), 0, 0, 1, 4'(i), 16'(i), 1);
    end
    step();
    check_port("init_exit", 0, 0, 0, 0, 0, 0);
    exp_q.push_back({4'd2, 16'hBEEF});
    step();
    check_port("post_init_gnt1", 0, 1, 1, 2, 16'hBEEF, 0);
    drive(0, 0, 0, 0, 0, 0);
    step();
    check_port("post_init_idle", 0, 0, 0, 0, 0, 0);

    // Abort the sweep at index 7.
    init_start = 1'b1;
    exp_q.push_back(20'h0);
    step();
    init_start = 1'b0;
    check_port("abort_init0", 0, 0, 1, 0, 0, 1);
    for (int i = 1; i < 8; i++) begin
      exp_q.push_back({4'(i), 16'(i)});
      step();
      check_port($sformatf("abort_init%0d", i), 0, 0, 1, 4'(i), 16'(i), 1);
    end
    #2;
    nClear = 1'b0;
    #1;
    check_port("abort_reset", 0, 0, 0, 0, 0, 0);
    step();
    nClear = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_port($sformatf("abort_after%0d", i), 0, 0, 0, 0, 0, 0);
      cmp($sformatf("abort_after%0d.dbg_state", i), 32'(dbg_state), 32'(ST_IDLE));
    end
`else
    init_start = 1'b1;
    step();
    init_start = 1'b0;
    check_port("no_init0", 0, 0, 0, 0, 0, 0);
    for (int i = 1; i < 4; i++) begin
      step();
      check_port($sformatf("no_init%0d", i), 0, 0, 0, 0, 0, 0);
    end
`endif

    cmp("sb_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on posedge.
REQ-002 SHALL have port: nClear  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: req0 / req1  input  1  write request from requester 0 / 1.
REQ-004 SHALL have ports: addr0 / addr1  input  4  target register address, held while req high.
REQ-005 SHALL have ports: data0 / data1  input  16  write data, held while req high.
REQ-006 SHALL have ports: gnt0 / gnt1  output  1  one-cycle grant pulse; request accepted.
REQ-007 SHALL have port: init_start  input  1  single-cycle pulse; starts an init sweep.
REQ-008 SHALL have port: init_busy  output  1  high while the init sweep is running.
REQ-009 SHALL have ports: Caddr  output  4 / C  output  16 / load  output  1  register-file write port.

Function
REQ-010 SHALL implement the states IDLE (arbitrate) and INIT (sweep); INIT exists only per REQ-024.
REQ-011 SHALL, in IDLE at posedge k, pick one eligible requester and register gntN=1, Caddr=addrN, C=dataN, load=1 for cycle k..k+1; the register file captures at edge k+1.
REQ-012 SHALL make a requester granted at edge k ineligible at edge k+1 (its req is still high); eligible again from edge k+2.
REQ-013 SHALL use round-robin when both are eligible: grant the one not granted last; last-grant pointer resets to 1, so requester 0 wins first.
REQ-014 SHALL drive gnt0=gnt1=0, load=0, Caddr=0, C=0 in any cycle with no grant; never assert gnt0 and gnt1 together.
REQ-015 SHALL sustain one write per cycle when both request continuously, alternating 0,1,0,1; a lone requester gets one write per two cycles.
REQ-016 SHALL, on init_start=1 in IDLE, enter INIT at that edge; init_start in INIT is ignored.
REQ-017 SHALL, in INIT, write Caddr=i, C={12'b0,i}, load=1 for i=0..15 on 16 consecutive cycles, then return to IDLE; init_busy=1 exactly those 16 cycles.
REQ-018 SHALL issue no grants during INIT; pending requests stay pending and arbitration resumes on the first IDLE edge.
REQ-019 SHALL give init_start priority over requests sampled at the same edge.
REQ-020 SHALL not merge or reorder: same-address requests from both sides are written serially in grant order.

Reset
REQ-021 SHALL, with nClear=0, immediately force IDLE, sweep index 0, last-grant=1, all outputs 0, independent of clk.
REQ-022 SHALL, on nClear low mid-INIT, abort the sweep; no further sweep writes after release.
REQ-023 SHALL make the first grant possible at the first posedge after nClear deasserts.

Configuration
REQ-024 SHALL, with RF_ARB_INIT_EN defined, include INIT, the sweep counter and init_busy behaviour; without it, ignore init_start, tie init_busy to 0, and omit all INIT logic.

Structure
REQ-025 SHALL take RF_ADDR_W=4, RF_DATA_W=16, RF_DEPTH=16 and the state encoding from shared package rf_pkg.
REQ-026 SHALL place the two-way round-robin pick (eligibility mask, last-grant pointer) in sub-module rf_rr_pick; FSM, counter and output registers stay in rf_write_arbiter.

Verification
REQ-027 SHALL cover: req0=1, addr0=3, data0=16'h00AA alone -> gnt0 after one edge, Caddr=3, C=16'h00AA, load=1 one cycle; next grant two cycles later if req0 held.
REQ-028 SHALL cover: req0 and req1 both high from the same edge (addr 4/5, data 11/15) -> grants 0,1,0,1 on consecutive cycles, never simultaneous.
REQ-029 SHALL cover: init_start with req1 high -> 16 cycles of Caddr=0..15, C=0..15, no gnt1; gnt1 on the cycle after init_busy falls.
REQ-030 SHALL cover: nClear pulsed low at sweep index 7 -> outputs 0 immediately, IDLE after release, no write to index 8.
REQ-031 SHALL cover: build without RF_ARB_INIT_EN, pulse init_start -> init_busy stays 0, load stays 0 with no requests.
REQ-032 SHALL cover: bench register-file model checks readback A/B at addr 4 and 5 equal the last granted data (11 and 15).
